// File: rtl/hdbn_line_encoder.sv
// NRZ-to-bipolar line encoder: HDBn zero substitution followed by alternate-mark
// polarity assignment onto the BP/BN line-driver pair, with identical latency in AMI and HDBn modes.
module hdbn_line_encoder #(
    parameter int ZRUN     = 4,
    parameter bit INIT_POL = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             mode,
    output logic             BP,
    output logic             BN,
    output logic             out_valid,
    output logic             v_pulse,
    output logic [CNT_W-1:0] sub_cnt
);

    localparam int ZC_W = (ZRUN > 1) ? $clog2(ZRUN) : 1;

    typedef enum logic [1:0] {
        CODE_ZERO = 2'b00,
        CODE_MARK = 2'b01,
        CODE_B    = 2'b10,
        CODE_V    = 2'b11
    } code_t;

    // en is a one-way strobe with no back-pressure: every clk with en=1 consumes
    // din and advances the whole pipeline by one bit; en=0 freezes it.
    code_t            sr_code [ZRUN];
    logic [ZRUN-1:0]  sr_vld;
    logic [ZC_W-1:0]  zcnt;
    logic             parity;
    logic             last_neg;

    logic             sub;
    code_t            new_code;
    logic             bp_next;
    logic             bn_next;
    logic             v_next;
    logic             last_neg_next;

    always_comb begin
        sub      = !din && mode && (zcnt == ZC_W'(ZRUN - 1));
        new_code = CODE_ZERO;
        if (din) begin
            new_code = CODE_MARK;
        end else if (sub) begin
            new_code = CODE_V;
        end
    end

    // Polarity stage: last_neg records the sign of the most recent pulse.
    always_comb begin
        bp_next       = 1'b0;
        bn_next       = 1'b0;
        v_next        = 1'b0;
        last_neg_next = last_neg;
        case (sr_code[ZRUN-1])
            CODE_MARK, CODE_B: begin
                bp_next       = last_neg;
                bn_next       = !last_neg;
                last_neg_next = !last_neg;
            end
            CODE_V: begin
                bp_next = !last_neg;
                bn_next = last_neg;
                v_next  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ZRUN; i++) begin
                sr_code[i] <= CODE_ZERO;
            end
            sr_vld    <= '0;
            zcnt      <= '0;
            parity    <= 1'b0;
            last_neg  <= (INIT_POL == 1'b0);
            BP        <= 1'b0;
            BN        <= 1'b0;
            out_valid <= 1'b0;
            v_pulse   <= 1'b0;
            sub_cnt   <= '0;
        end else if (en) begin
            for (int i = 1; i < ZRUN; i++) begin
                sr_code[i] <= sr_code[i-1];
                sr_vld[i]  <= sr_vld[i-1];
            end
            sr_code[0] <= new_code;
            sr_vld[0]  <= 1'b1;
            // Even pulse count since the last violation: prepend a B so V alternates.
            if (sub && !parity && sr_vld[ZRUN-2]) begin
                sr_code[ZRUN-1] <= CODE_B;
            end

            if (din) begin
                zcnt   <= '0;
                parity <= !parity;
            end else if (!mode || sub) begin
                zcnt <= '0;
                if (sub) begin
                    parity <= 1'b0;
                end
            end else begin
                zcnt <= zcnt + 1'b1;
            end

            if (sub && (sub_cnt != {CNT_W{1'b1}})) begin
                sub_cnt <= sub_cnt + 1'b1;
            end

            BP        <= bp_next;
            BN        <= bn_next;
            v_pulse   <= v_next;
            out_valid <= sr_vld[ZRUN-1];
            last_neg  <= last_neg_next;
        end else begin
            v_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hdbn_line_encoder.sv
// Directed bench for hdbn_line_encoder (ZRUN=4, INIT_POL=0, narrow substitution counter
// so saturation is reachable); each scenario task carries its own hand-computed expectations.
module tb_hdbn_line_encoder;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             din;
    logic             mode;
    logic             BP;
    logic             BN;
    logic             out_valid;
    logic             v_pulse;
    logic [CNT_W-1:0] sub_cnt;

    int n_checks;
    int n_fail;

    int   obs_pulse [$];
    logic obs_vld   [$];
    logic obs_v     [$];

    hdbn_line_encoder #(
        .ZRUN     (4),
        .INIT_POL (1'b0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .mode      (mode),
        .BP        (BP),
        .BN        (BN),
        .out_valid (out_valid),
        .v_pulse   (v_pulse),
        .sub_cnt   (sub_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // +1 positive, -1 negative, 0 no pulse, 2 illegal BP=BN=1
    function automatic int pulse_of();
        if (BP && !BN) return 1;
        if (!BP && BN) return -1;
        if (!BP && !BN) return 0;
        return 2;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        en    = 1'b0;
        din   = 1'b0;
        mode  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        obs_pulse.delete();
        obs_vld.delete();
        obs_v.delete();
    endtask

    task automatic drive_bit(input logic d, input logic m);
        @(negedge clk);
        en   = 1'b1;
        din  = d;
        mode = m;
        @(posedge clk);
        #1;
        obs_pulse.push_back(pulse_of());
        obs_vld.push_back(out_valid);
        obs_v.push_back(v_pulse);
    endtask

    task automatic idle_clk();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
        idle_clk();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if (BP !== 1'b0 || BN !== 1'b0 || out_valid !== 1'b0 || v_pulse !== 1'b0 || sub_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_values: BP=%b BN=%b out_valid=%b v_pulse=%b sub_cnt=%0d, required all zero",
                     BP, BN, out_valid, v_pulse, sub_cnt);
        end
    endtask

    task automatic test_ami();
        int exp_p [4] = '{1, -1, 0, 1};
        apply_reset();
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        flush(4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_pulse[i+4] !== exp_p[i]) begin
                n_fail++;
                $display("FAIL ami_pulse[%0d]: got %0d, required %0d", i, obs_pulse[i+4], exp_p[i]);
            end
        end
        n_checks++;
        if (obs_vld[3] !== 1'b0 || obs_vld[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL ami_out_valid_rise: strobe4=%b strobe5=%b, required 0 then 1", obs_vld[3], obs_vld[4]);
        end
        n_checks++;
        if (sub_cnt !== '0) begin
            n_fail++;
            $display("FAIL ami_sub_cnt: got %0d, required 0", sub_cnt);
        end
    endtask

    task automatic test_hdb3_000v();
        int   exp_p [5] = '{1, 0, 0, 0, 1};
        logic exp_v [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        drive_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
        flush(4);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs_pulse[i+4] !== exp_p[i] || obs_v[i+4] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL hdb3_000v[%0d]: pulse=%0d v=%b, required pulse=%0d v=%b",
                         i, obs_pulse[i+4], obs_v[i+4], exp_p[i], exp_v[i]);
            end
        end
        n_checks++;
        if (sub_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL hdb3_000v_sub_cnt: got %0d, required 1", sub_cnt);
        end
    endtask

    task automatic test_hdb3_b00v();
        int   exp_p [6] = '{1, -1, 1, 0, 0, 1};
        logic exp_v [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
        flush(4);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs_pulse[i+4] !== exp_p[i] || obs_v[i+4] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL hdb3_b00v[%0d]: pulse=%0d v=%b, required pulse=%0d v=%b",
                         i, obs_pulse[i+4], obs_v[i+4], exp_p[i], exp_v[i]);
            end
        end
        n_checks++;
        if (sub_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL hdb3_b00v_sub_cnt: got %0d, required 1", sub_cnt);
        end
    endtask

    task automatic test_eight_zeros();
        int   exp_p [8] = '{1, 0, 0, 1, -1, 0, 0, -1};
        logic exp_v [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 8; i++) drive_bit(1'b0, 1'b1);
        flush(4);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs_pulse[i+4] !== exp_p[i] || obs_v[i+4] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL eight_zeros[%0d]: pulse=%0d v=%b, required pulse=%0d v=%b",
                         i, obs_pulse[i+4], obs_v[i+4], exp_p[i], exp_v[i]);
            end
        end
        n_checks++;
        if (sub_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL eight_zeros_sub_cnt: got %0d, required 2", sub_cnt);
        end
    endtask

    task automatic test_mode_straddle();
        int exp_p [7] = '{1, 0, 0, 0, 0, 0, 1};
        apply_reset();
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
        n_checks++;
        if (sub_cnt !== '0) begin
            n_fail++;
            $display("FAIL straddle_no_early_sub: got %0d, required 0", sub_cnt);
        end
        drive_bit(1'b0, 1'b1);
        flush(4);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (obs_pulse[i+4] !== exp_p[i]) begin
                n_fail++;
                $display("FAIL straddle_pulse[%0d]: got %0d, required %0d", i, obs_pulse[i+4], exp_p[i]);
            end
        end
        n_checks++;
        if (sub_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL straddle_sub_cnt: got %0d, required 1", sub_cnt);
        end
    endtask

    // Same 000V stream as test_hdb3_000v with two idle clocks between strobes.
    task automatic test_en_gaps();
        int   exp_p [5] = '{1, 0, 0, 0, 1};
        logic bits  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic modes [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int   held_p;
        logic held_vld;
        logic [CNT_W-1:0] held_cnt;
        int   frozen_bad;
        apply_reset();
        frozen_bad = 0;
        for (int k = 0; k < 9; k++) begin
            drive_bit(bits[k], modes[k]);
            held_p   = pulse_of();
            held_vld = out_valid;
            held_cnt = sub_cnt;
            for (int j = 0; j < 2; j++) begin
                idle_clk();
                if (pulse_of() !== held_p || out_valid !== held_vld || sub_cnt !== held_cnt || v_pulse !== 1'b0)
                    frozen_bad++;
            end
        end
        n_checks++;
        if (frozen_bad !== 0) begin
            n_fail++;
            $display("FAIL en_gap_frozen: %0d idle samples changed or kept v_pulse, required 0", frozen_bad);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs_pulse[i+4] !== exp_p[i]) begin
                n_fail++;
                $display("FAIL en_gap_pulse[%0d]: got %0d, required %0d", i, obs_pulse[i+4], exp_p[i]);
            end
        end
        n_checks++;
        if (obs_v[8] !== 1'b1 || sub_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL en_gap_v_and_count: v=%b sub_cnt=%0d, required v=1 sub_cnt=1", obs_v[8], sub_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int v_seen;
        int pulse_seen;
        apply_reset();
        drive_bit(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) drive_bit(1'b0, 1'b1);
        n_checks++;
        if (sub_cnt !== 3'd1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: sub_cnt=%0d out_valid=%b, required 1 and 1", sub_cnt, out_valid);
        end
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (BP !== 1'b0 || BN !== 1'b0 || out_valid !== 1'b0 || sub_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: BP=%b BN=%b out_valid=%b sub_cnt=%0d, required all zero",
                     BP, BN, out_valid, sub_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        obs_pulse.delete();
        obs_vld.delete();
        obs_v.delete();
        drive_bit(1'b0, 1'b1);
        flush(4);
        v_seen = 0;
        pulse_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (obs_v[i]) v_seen++;
            if (obs_pulse[i] != 0) pulse_seen++;
        end
        n_checks++;
        if (v_seen !== 0 || pulse_seen !== 0 || sub_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_no_sub: v=%0d pulses=%0d sub_cnt=%0d, required 0 0 0", v_seen, pulse_seen, sub_cnt);
        end
        n_checks++;
        if (obs_vld[3] !== 1'b0 || obs_vld[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_valid: strobe4=%b strobe5=%b, required 0 then 1", obs_vld[3], obs_vld[4]);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 28; i++) drive_bit(1'b0, 1'b1);
        n_checks++;
        if (sub_cnt !== 3'd7) begin
            n_fail++;
            $display("FAIL sat_reach_max: got %0d, required 7", sub_cnt);
        end
        for (int i = 0; i < 8; i++) drive_bit(1'b0, 1'b1);
        n_checks++;
        if (sub_cnt !== 3'd7) begin
            n_fail++;
            $display("FAIL sat_hold_max: got %0d, required 7", sub_cnt);
        end
        idle_clk();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        din      = 1'b0;
        mode     = 1'b0;
        test_reset();
        test_ami();
        test_hdb3_000v();
        test_hdb3_b00v();
        test_eight_zeros();
        test_mode_straddle();
        test_en_gaps();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
